spi_slave_frame: RTL and testbench

- Parametrised SPI slave linking the microcontroller to the synth core. It generalises the fixed 32-bit, mode-0, free-running soft SPI.
- Adds chip-select framing, all four SPI modes, and configurable address, data and sample widths.
- Input pins are synchronised internally. Frame errors are detected, and register writes leave the block as single-cycle pulses.
- Sits between the top-level SPI pins and the register file / sample pipeline.

---
 rtl/spi_pkg.sv | 42 ++++
 rtl/spi_slave_frame_if.sv | 25 ++
 rtl/spi_pin_sync.sv | 28 ++
 rtl/spi_slave_frame.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_frame.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the framed SPI slave.
// Mode encoding, frame width derivation and frame bit offsets.
package spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  // Offsets counted from the frame MSB.
  localparam int WFLAG_OFS = 0;
  localparam int ADDR_OFS  = 1;

  function automatic int frame_width(
    input int aw,
    input int dw
  );
    return 1 + aw + dw;
  endfunction

  function automatic spi_mode_t mode_of(
    input bit cpol,
    input bit cpha
  );
    return spi_mode_t'({cpol, cpha});
  endfunction

  function automatic bit mode_cpol(
    input spi_mode_t m
  );
    return m[1];
  endfunction

  function automatic bit mode_cpha(
    input spi_mode_t m
  );
    return m[0];
  endfunction

endpackage

// File: rtl/spi_slave_frame_if.sv
// Register-write bundle leaving the SPI slave.
// The slave drives it; the register file consumes it.
interface spi_slave_frame_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] num;
  logic [DATA_WIDTH-1:0] val;
  logic                  err;

  modport master (
    output we,
    output num,
    output val,
    output err
  );

  modport slave (
    input we,
    input num,
    input val,
    input err
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop pin synchroniser with rise/fall detect
// taken from the last two synchronised stages.
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = sr[STAGES-2] & ~sr[STAGES-1];
  assign fall = ~sr[STAGES-2] & sr[STAGES-1];

endmodule

// File: rtl/spi_slave_frame.sv
// CS-framed SPI slave: all four modes, register-write
// pulses, frame error detection and sample transmit on MISO.
module spi_slave_frame
  import spi_pkg::*;
#(
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 16,
  parameter int SAMPLE_WIDTH = 16,
  parameter bit CPOL         = 1'b0,
  parameter bit CPHA         = 1'b0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset_n,
  input  logic                    i_SampleReady,
  input  logic [SAMPLE_WIDTH-1:0] i_Sample,
  output logic                    o_RegisterWriteEnable,
  output logic [ADDR_WIDTH-1:0]   o_RegisterWriteNumber,
  output logic [DATA_WIDTH-1:0]   o_RegisterWriteValue,
  output logic                    o_FrameError,
  input  logic                    i_SPI_SCK,
  input  logic                    i_SPI_CS_n,
  input  logic                    i_SPI_MOSI,
  output logic                    o_SPI_MISO
);

  localparam int FW = frame_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int CW = $clog2(FW + 2);
  localparam spi_mode_t MODE = mode_of(CPOL, CPHA);
  localparam bit LEAD_FALL  = mode_cpol(MODE);
  localparam bit SAMP_TRAIL = mode_cpha(MODE);
  localparam int FLAG_IDX = FW - 1 - WFLAG_OFS;
  localparam int ADDR_MSB = FW - 1 - ADDR_OFS;
  localparam logic [CW-1:0] CNT_LAST = CW'(FW - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FW);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FW + 1);

  typedef logic [FW-1:0] frame_t;

  spi_slave_frame_if #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) bus ();

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic unused_pins;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sck (
    .clk  (i_Clock),
    .rst_n(i_Reset_n),
    .d    (i_SPI_SCK),
    .q    (sck_q),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs (
    .clk  (i_Clock),
    .rst_n(i_Reset_n),
    .d    (i_SPI_CS_n),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk  (i_Clock),
    .rst_n(i_Reset_n),
    .d    (i_SPI_MOSI),
    .q    (mosi_q),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  assign unused_pins = ^{sck_q, mosi_rise, mosi_fall};

  logic                    armed;
  logic                    first;
  logic                    miso;
  logic [CW-1:0]           cnt;
  frame_t                  rx;
  frame_t                  tx;
  logic [SAMPLE_WIDTH-1:0] hold;

  logic lead, trail, samp, shft;
  logic active, start, stop;
  logic [SAMPLE_WIDTH-1:0] hold_next;
  frame_t tx_load, rx_next;

  assign lead  = LEAD_FALL ? sck_fall : sck_rise;
  assign trail = LEAD_FALL ? sck_rise : sck_fall;
  assign samp  = SAMP_TRAIL ? trail : lead;
  assign shft  = SAMP_TRAIL ? lead : trail;

  assign active = armed & ~cs_q;
  assign start  = armed & cs_fall;
  assign stop   = armed & cs_rise;

  assign hold_next = i_SampleReady ? i_Sample : hold;
  assign tx_load   = frame_t'(hold_next) << (FW - SAMPLE_WIDTH);
  assign rx_next   = {rx[FW-2:0], mosi_q};

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      armed   <= 1'b0;
      first   <= 1'b0;
      miso    <= 1'b0;
      cnt     <= '0;
      rx      <= '0;
      tx      <= '0;
      hold    <= '0;
      bus.we  <= 1'b0;
      bus.num <= '0;
      bus.val <= '0;
      bus.err <= 1'b0;
    end else begin
      bus.we  <= 1'b0;
      bus.err <= 1'b0;
      hold    <= hold_next;
      if (cs_q) armed <= 1'b1;
      if (start) begin
        cnt   <= '0;
        tx    <= tx_load;
        first <= 1'b1;
        if (!SAMP_TRAIL) miso <= tx_load[FW-1];
      end else if (stop) begin
        miso <= 1'b0;
        if (cnt != CNT_FULL) bus.err <= 1'b1;
      end else if (active) begin
        if (samp) begin
          rx <= rx_next;
          if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST && rx_next[FLAG_IDX]) begin
            bus.we  <= 1'b1;
            bus.num <= rx_next[ADDR_MSB -: ADDR_WIDTH];
            bus.val <= rx_next[DATA_WIDTH-1:0];
          end
        end
        // CPHA=1: first leading edge only presents the MSB
        if (shft) begin
          if (SAMP_TRAIL && first) begin
            miso  <= tx[FW-1];
            first <= 1'b0;
          end else begin
            tx   <= {tx[FW-2:0], 1'b0};
            miso <= tx[FW-2];
          end
        end
      end
    end
  end

  assign o_RegisterWriteEnable = bus.we;
  assign o_RegisterWriteNumber = bus.num;
  assign o_RegisterWriteValue  = bus.val;
  assign o_FrameError          = bus.err;
  assign o_SPI_MISO            = miso;

endmodule

// File: tb/tb_spi_slave_frame.sv
// Scoreboard bench: four slaves, one per SPI mode,
// driven by a bit-banged master at clk/8.
module tb_spi_slave_frame;
  import spi_pkg::*;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int SW = 16;

  typedef struct packed {
    logic [1:0]    m;
    logic [AW-1:0] num;
    logic [DW-1:0] val;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sready = 1'b0;
  logic [SW-1:0] sample = '0;
  logic [3:0]    sck;
  logic [3:0]    cs_n;
  logic          mosi;
  logic [3:0]    miso;
  logic [3:0]    we;
  logic [3:0]    err;
  logic [AW-1:0] num [4];
  logic [DW-1:0] val [4];

  int vecs = 0;
  int bad = 0;

  wr_t         exp_wr[$];
  int          exp_err[$];
  logic [31:0] exp_miso[$];
  logic [31:0] obs_miso[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_frame_if #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
    ) rif ();

    spi_slave_frame #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .SAMPLE_WIDTH(SW),
      .CPOL        (g >= 2),
      .CPHA        (g % 2 == 1),
      .SYNC_STAGES (2)
    ) dut (
      .i_Clock              (clk),
      .i_Reset_n            (rst_n),
      .i_SampleReady        (sready),
      .i_Sample             (sample),
      .o_RegisterWriteEnable(rif.we),
      .o_RegisterWriteNumber(rif.num),
      .o_RegisterWriteValue (rif.val),
      .o_FrameError         (rif.err),
      .i_SPI_SCK            (sck[g]),
      .i_SPI_CS_n           (cs_n[g]),
      .i_SPI_MOSI           (mosi),
      .o_SPI_MISO           (miso[g])
    );

    assign we[g]  = rif.we;
    assign err[g] = rif.err;
    assign num[g] = rif.num;
    assign val[g] = rif.val;
  end

  task automatic chk(
    input string      name,
    input logic [63:0] act,
    input logic [63:0] req
  );
    vecs++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, need %0h", name, act, req);
    end
  endtask

  task automatic load(input logic [SW-1:0] x);
    @(negedge clk);
    sready = 1'b1;
    sample = x;
    @(negedge clk);
    sready = 1'b0;
  endtask

  task automatic frame(
    input  int          m,
    input  int          n,
    input  logic [63:0] d,
    input  int          rst_at,
    output logic [31:0] mw
  );
    bit cpol;
    bit cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    mw = '0;
    if (!cpha) mosi = d[n-1];
    cs_n[m] = 1'b0;
    #80;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #30;
        rst_n = 1'b1;
        #20;
      end
      if (cpha) mosi = d[n-1-i];
      sck[m] = ~cpol;
      if (!cpha && i < 32) mw[31-i] = miso[m];
      #40;
      sck[m] = cpol;
      if (cpha && i < 32) mw[31-i] = miso[m];
      if (!cpha && i < n - 1) mosi = d[n-2-i];
      #40;
    end
    cs_n[m] = 1'b1;
    #120;
  endtask

  task automatic run(
    input int            m,
    input int            n,
    input logic [63:0]   d,
    input bit            w,
    input logic [AW-1:0] wn,
    input logic [DW-1:0] wv,
    input bit            e,
    input bit            mck
  );
    logic [31:0] mw;
    if (w) exp_wr.push_back(wr_t'{m[1:0], wn, wv});
    if (e) exp_err.push_back(m);
    if (mck) exp_miso.push_back(32'hA5C3_0000);
    frame(m, n, d, -1, mw);
    if (mck) obs_miso.push_back(mw);
  endtask

  // Monitor: every output event is matched against the queues.
  initial begin
    forever begin
      @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        if (we[m]) begin
          if (exp_wr.size() == 0) begin
            vecs++;
            bad++;
            $display("FAIL spurious_write m%0d: got num %0h val %0h, need none",
                     m, num[m], val[m]);
          end else begin
            wr_t e;
            wr_t a;
            e = exp_wr.pop_front();
            a = wr_t'{m[1:0], num[m], val[m]};
            chk("write", 64'(a), 64'(e));
          end
        end
        if (err[m]) begin
          if (exp_err.size() == 0) begin
            vecs++;
            bad++;
            $display("FAIL spurious_error m%0d: got pulse, need none", m);
          end else begin
            chk("error_mode", 64'(m), 64'(exp_err.pop_front()));
          end
        end
      end
      if (obs_miso.size() != 0 && exp_miso.size() != 0) begin
        chk("miso_word", 64'(obs_miso.pop_front()), 64'(exp_miso.pop_front()));
      end
    end
  end

  initial begin
    logic [31:0] mw;
    sck  = 4'b1100;
    cs_n = 4'hF;
    mosi = 1'b0;
    #50;
    for (int m = 0; m < 4; m++) begin
      chk("rst_we", 64'(we[m]), 64'd0);
      chk("rst_err", 64'(err[m]), 64'd0);
      chk("rst_miso", 64'(miso[m]), 64'd0);
      chk("rst_numval", 64'({num[m], val[m]}), 64'd0);
    end
    rst_n = 1'b1;
    #100;
    load(16'hA5C3);

    run(0, 32, 64'h8005_1234, 1, 15'h0005, 16'h1234, 0, 1);
    run(1, 32, 64'h8011_1111, 1, 15'h0011, 16'h1111, 0, 1);
    run(2, 32, 64'h8022_2222, 1, 15'h0022, 16'h2222, 0, 1);
    run(3, 32, 64'h8033_3333, 1, 15'h0033, 16'h3333, 0, 1);
    run(0, 32, 64'h0003_FFFF, 0, '0, '0, 0, 1);
    run(0, 20, 64'h0008_0044, 0, '0, '0, 1, 0);
    run(0, 32, 64'h8001_0001, 1, 15'h0001, 16'h0001, 0, 1);
    run(0, 34, {30'd0, 32'h8007_00FF, 2'b11},
        1, 15'h0007, 16'h00FF, 1, 1);

    frame(0, 32, 64'h8009_9999, 16, mw);
    load(16'hA5C3);
    run(0, 32, 64'h8012_ABCD, 1, 15'h0012, 16'hABCD, 0, 1);
    run(3, 20, 64'h0008_0011, 0, '0, '0, 1, 0);

    #300;
    while (exp_wr.size() != 0) begin
      wr_t e;
      e = exp_wr.pop_front();
      vecs++;
      bad++;
      $display("FAIL missing_write: got none, need m%0d num %0h val %0h",
               e.m, e.num, e.val);
    end
    while (exp_err.size() != 0) begin
      vecs++;
      bad++;
      $display("FAIL missing_error: got none, need pulse on m%0d",
               exp_err.pop_front());
    end
    while (exp_miso.size() != 0) begin
      vecs++;
      bad++;
      $display("FAIL missing_miso: got none, need %0h", exp_miso.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
